// File: rtl/mem_access_ctrl.sv
// Turns level-held LC-3 Mem_OE/Mem_WE requests into timed async SRAM cycles, with a memory-mapped I/O port.
// Latency: I/O 1 cycle; SRAM read WAIT_CYCLES+1 cycles; SRAM write WAIT_CYCLES+2 cycles to the Mem_R strobe.
// Backpressure: none; a held request is served once, then the block parks in HOLD until both requests drop.
module mem_access_ctrl #(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] Switches,
    input  logic [15:0] SRAM_DQ_in,
    output logic        Mem_R,
    output logic [15:0] Data_out,
    output logic [15:0] HEX_Reg,
    output logic [19:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int WAIT_CLAMP = (WAIT_CYCLES < 1) ? 1 :
                                ((WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES);
    localparam logic [3:0] WAIT_M1 = 4'(WAIT_CLAMP - 1);

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_DONE, IO_DONE, HOLD
    } state_t;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic bs_n;
        logic dq_oe;
    } sram_ctl_t;

    state_t      state_q, state_nxt;
    logic [3:0]  cnt_q, cnt_nxt;
    sram_ctl_t   ctl_q, ctl_nxt;
    logic        mem_r_q, mem_r_nxt;
    logic [15:0] addr_q, wr_dat_q, rd_dat_q, hex_q;
    logic        req_vld, is_io;
    logic        ld_sram, rd_cap, io_rd, io_wr;

    assign req_vld = Mem_OE | Mem_WE;
    assign is_io   = (MAR == IO_ADDR);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        ld_sram   = 1'b0;
        rd_cap    = 1'b0;
        io_rd     = 1'b0;
        io_wr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    if (is_io) begin
                        // I/O never touches the SRAM address or strobes
                        state_nxt = IO_DONE;
                        io_wr     = Mem_WE;
                        io_rd     = ~Mem_WE;
                    end else begin
                        ld_sram = 1'b1;
                        if (Mem_WE) begin
                            state_nxt = WR_SETUP;
                        end else begin
                            state_nxt = RD_WAIT;
                            cnt_nxt   = WAIT_M1;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_nxt = RD_DONE;
                    rd_cap    = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - 4'd1;
                end
            end
            RD_DONE: state_nxt = HOLD;
            WR_SETUP: begin
                state_nxt = WR_PULSE;
                cnt_nxt   = WAIT_M1;
            end
            WR_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_nxt = WR_DONE;
                end else begin
                    cnt_nxt = cnt_q - 4'd1;
                end
            end
            WR_DONE: state_nxt = HOLD;
            IO_DONE: state_nxt = HOLD;
            HOLD: begin
                if (!Mem_OE && !Mem_WE) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Strobes are decoded from the next state so the pins come straight off flops
        ctl_nxt.ce_n  = ~(state_nxt inside {RD_WAIT, WR_SETUP, WR_PULSE, WR_DONE});
        ctl_nxt.bs_n  = ctl_nxt.ce_n;
        ctl_nxt.oe_n  = (state_nxt != RD_WAIT);
        ctl_nxt.we_n  = (state_nxt != WR_PULSE);
        ctl_nxt.dq_oe = (state_nxt inside {WR_SETUP, WR_PULSE, WR_DONE});
        mem_r_nxt     = (state_nxt inside {RD_DONE, WR_DONE, IO_DONE});
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ctl_q    <= '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, bs_n: 1'b1, dq_oe: 1'b0};
            mem_r_q  <= 1'b0;
            addr_q   <= 16'd0;
            wr_dat_q <= 16'd0;
            rd_dat_q <= 16'd0;
            hex_q    <= 16'd0;
        end else begin
            ctl_q   <= ctl_nxt;
            mem_r_q <= mem_r_nxt;
            if (ld_sram) begin
                addr_q   <= MAR;
                wr_dat_q <= MDR;
            end
            if (io_wr) begin
                hex_q <= MDR;
            end
            if (io_rd) begin
                rd_dat_q <= Switches;
            end
            if (rd_cap) begin
                rd_dat_q <= SRAM_DQ_in;
            end
        end
    end

    assign Mem_R       = mem_r_q;
    assign Data_out    = rd_dat_q;
    assign HEX_Reg     = hex_q;
    assign SRAM_ADDR   = {4'b0000, addr_q};
    assign SRAM_DQ_out = wr_dat_q;
    assign SRAM_DQ_oe  = ctl_q.dq_oe;
    assign SRAM_CE_N   = ctl_q.ce_n;
    assign SRAM_OE_N   = ctl_q.oe_n;
    assign SRAM_WE_N   = ctl_q.we_n;
    assign SRAM_UB_N   = ctl_q.bs_n;
    assign SRAM_LB_N   = ctl_q.bs_n;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: dut0 runs WAIT_CYCLES=3, dut1 runs WAIT_CYCLES=0,
// each against its own small behavioural SRAM.
module tb_mem_access_ctrl;

    logic        Clk, Reset;
    logic        Mem_OE, Mem_WE, oe1, we1;
    logic [15:0] MAR, MDR, Switches;

    logic        mem_r0, dq_oe0, ce_n0, oe_n0, we_n0, ub_n0, lb_n0;
    logic [15:0] data0, hex0, dq_out0, dq_in0;
    logic [19:0] addr0;
    logic        mem_r1, dq_oe1, ce_n1, oe_n1, we_n1, ub_n1, lb_n1;
    logic [15:0] data1, hex1, dq_out1, dq_in1;
    logic [19:0] addr1;

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];

    int n_vec = 0;
    int n_err = 0;
    int oe_conflict = 0;
    int cyc = 0;

    logic        r_h  [2][64];
    logic        we_h [2][64];
    logic        ce_h [2][64];
    logic        oe_h [2][64];
    logic        dq_h [2][64];
    logic [19:0] ad_h [64];

    mem_access_ctrl #(.WAIT_CYCLES(3), .IO_ADDR(16'hFFFF)) dut0 (
        .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .MAR(MAR), .MDR(MDR), .Switches(Switches), .SRAM_DQ_in(dq_in0),
        .Mem_R(mem_r0), .Data_out(data0), .HEX_Reg(hex0), .SRAM_ADDR(addr0),
        .SRAM_DQ_out(dq_out0), .SRAM_DQ_oe(dq_oe0), .SRAM_CE_N(ce_n0),
        .SRAM_OE_N(oe_n0), .SRAM_WE_N(we_n0), .SRAM_UB_N(ub_n0), .SRAM_LB_N(lb_n0)
    );

    mem_access_ctrl #(.WAIT_CYCLES(0), .IO_ADDR(16'hFFFF)) dut1 (
        .Clk(Clk), .Reset(Reset), .Mem_OE(oe1), .Mem_WE(we1),
        .MAR(MAR), .MDR(MDR), .Switches(Switches), .SRAM_DQ_in(dq_in1),
        .Mem_R(mem_r1), .Data_out(data1), .HEX_Reg(hex1), .SRAM_ADDR(addr1),
        .SRAM_DQ_out(dq_out1), .SRAM_DQ_oe(dq_oe1), .SRAM_CE_N(ce_n1),
        .SRAM_OE_N(oe_n1), .SRAM_WE_N(we_n1), .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Async SRAM models: read data appears while CE/OE are low, writes land while CE/WE are low
    assign dq_in0 = (!ce_n0 && !oe_n0) ? mem0[addr0[7:0]] : 16'h0000;
    assign dq_in1 = (!ce_n1 && !oe_n1) ? mem1[addr1[7:0]] : 16'h0000;

    always @(posedge Clk) begin
        if (!ce_n0 && !we_n0 && dq_oe0) mem0[addr0[7:0]] <= dq_out0;
        if (!ce_n1 && !we_n1 && dq_oe1) mem1[addr1[7:0]] <= dq_out1;
    end

    always @(negedge Clk) begin
        if ((!oe_n0 && dq_oe0) || (!oe_n1 && dq_oe1)) oe_conflict++;
    end

    task automatic start_rec();
        cyc = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (cyc < 64) begin
                r_h[0][cyc] = mem_r0;  r_h[1][cyc] = mem_r1;
                we_h[0][cyc] = we_n0;  we_h[1][cyc] = we_n1;
                ce_h[0][cyc] = ce_n0;  ce_h[1][cyc] = ce_n1;
                oe_h[0][cyc] = oe_n0;  oe_h[1][cyc] = oe_n1;
                dq_h[0][cyc] = dq_oe0; dq_h[1][cyc] = dq_oe1;
                ad_h[cyc] = addr0;
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] strobes;
        strobes = {ce_n0, oe_n0, we_n0, ub_n0, lb_n0};
        n_vec++;
        if (strobes !== 5'b11111) begin
            n_err++; $display("FAIL reset_strobes got %b want 11111", strobes);
        end
        n_vec++;
        if ({mem_r0, dq_oe0} !== 2'b00) begin
            n_err++; $display("FAIL reset_memr_oe got %b want 00", {mem_r0, dq_oe0});
        end
        n_vec++;
        if ({data0, hex0, addr0} !== 52'd0) begin
            n_err++; $display("FAIL reset_regs got %h/%h/%h want 0/0/0", data0, hex0, addr0);
        end
    endtask

    task automatic test_read();
        int nlow_we, nlow_oe;
        start_rec();
        Mem_OE = 1'b1; MAR = 16'h0010;
        run(8);
        nlow_we = 0; nlow_oe = 0;
        for (int c = 1; c <= 8; c++) begin
            n_vec++;
            if (r_h[0][c] !== (c == 4)) begin
                n_err++; $display("FAIL rd_mem_r cycle %0d got %b want %b", c, r_h[0][c], (c == 4));
            end
            if (!we_h[0][c]) nlow_we++;
            if (!oe_h[0][c]) nlow_oe++;
        end
        n_vec++;
        if (nlow_we !== 0) begin n_err++; $display("FAIL rd_we_n low cycles got %0d want 0", nlow_we); end
        n_vec++;
        if (nlow_oe !== 3) begin n_err++; $display("FAIL rd_oe_n low cycles got %0d want 3", nlow_oe); end
        n_vec++;
        if (ad_h[1] !== 20'h00010) begin n_err++; $display("FAIL rd_addr got %h want 00010", ad_h[1]); end
        n_vec++;
        if (data0 !== 16'h1234) begin n_err++; $display("FAIL rd_data got %h want 1234", data0); end
        Mem_OE = 1'b0;
        run(2);
    endtask

    task automatic test_write();
        int nwe, first, last, ndq, nr;
        start_rec();
        Mem_WE = 1'b1; MAR = 16'h0020; MDR = 16'hBEEF;
        run(8);
        nwe = 0; first = 0; last = 0; ndq = 0; nr = 0;
        for (int c = 1; c <= 8; c++) begin
            if (!we_h[0][c]) begin
                nwe++;
                if (first == 0) first = c;
                last = c;
            end
            if (dq_h[0][c]) ndq++;
            if (r_h[0][c]) nr++;
        end
        n_vec++;
        if ({nwe, first, last} !== {32'd3, 32'd2, 32'd4}) begin
            n_err++; $display("FAIL wr_we_pulse got n=%0d %0d..%0d want n=3 2..4", nwe, first, last);
        end
        n_vec++;
        if (ndq !== 5 || dq_h[0][1] !== 1'b1 || dq_h[0][5] !== 1'b1) begin
            n_err++; $display("FAIL wr_dq_oe got %0d cycles (c1=%b c5=%b) want 5 cycles 1..5", ndq, dq_h[0][1], dq_h[0][5]);
        end
        n_vec++;
        if (nr !== 1 || r_h[0][5] !== 1'b1) begin
            n_err++; $display("FAIL wr_mem_r got %0d pulses (c5=%b) want 1 at cycle 5", nr, r_h[0][5]);
        end
        n_vec++;
        if (mem0[8'h20] !== 16'hBEEF) begin n_err++; $display("FAIL wr_stored got %h want beef", mem0[8'h20]); end
        n_vec++;
        if (oe_conflict !== 0) begin n_err++; $display("FAIL wr_oe_conflict got %0d want 0", oe_conflict); end
        Mem_WE = 1'b0;
        run(2);
    endtask

    task automatic test_io();
        int nce;
        start_rec();
        Mem_OE = 1'b1; MAR = 16'hFFFF; Switches = 16'h00A5;
        run(4);
        n_vec++;
        if ({r_h[0][1], r_h[0][2], r_h[0][3], r_h[0][4]} !== 4'b1000) begin
            n_err++; $display("FAIL io_rd_mem_r got %b want 1000", {r_h[0][1], r_h[0][2], r_h[0][3], r_h[0][4]});
        end
        n_vec++;
        if (data0 !== 16'h00A5) begin n_err++; $display("FAIL io_rd_data got %h want 00a5", data0); end
        Mem_OE = 1'b0;
        run(2);
        Mem_WE = 1'b1; MDR = 16'h0042; Switches = 16'h0000;
        run(3);
        nce = 0;
        for (int c = 1; c <= 9; c++) if (!ce_h[0][c]) nce++;
        n_vec++;
        if (hex0 !== 16'h0042) begin n_err++; $display("FAIL io_wr_hex got %h want 0042", hex0); end
        n_vec++;
        if (r_h[0][7] !== 1'b1 || r_h[0][8] !== 1'b0) begin
            n_err++; $display("FAIL io_wr_mem_r got c7=%b c8=%b want 1 0", r_h[0][7], r_h[0][8]);
        end
        n_vec++;
        if (nce !== 0) begin n_err++; $display("FAIL io_ce_n low cycles got %0d want 0", nce); end
        n_vec++;
        if (data0 !== 16'h00A5) begin n_err++; $display("FAIL io_data_hold got %h want 00a5", data0); end
        Mem_WE = 1'b0;
        run(2);
    endtask

    task automatic test_level_hold();
        int nr;
        start_rec();
        Mem_OE = 1'b1; MAR = 16'h0010;
        run(2);
        MAR = 16'h0030;
        run(18);
        nr = 0;
        for (int c = 1; c <= 20; c++) if (r_h[0][c]) nr++;
        n_vec++;
        if (nr !== 1) begin n_err++; $display("FAIL hold_one_pulse got %0d want 1", nr); end
        n_vec++;
        if (ad_h[3] !== 20'h00010) begin n_err++; $display("FAIL hold_addr got %h want 00010", ad_h[3]); end
        n_vec++;
        if (data0 !== 16'h1234) begin n_err++; $display("FAIL hold_data got %h want 1234", data0); end
        Mem_OE = 1'b0;
        run(2);
        start_rec();
        Mem_OE = 1'b1;
        run(6);
        n_vec++;
        if (r_h[0][4] !== 1'b1 || data0 !== 16'h5555) begin
            n_err++; $display("FAIL hold_second got mem_r=%b data=%h want 1 5555", r_h[0][4], data0);
        end
        Mem_OE = 1'b0;
        run(2);
    endtask

    task automatic test_both_and_reset();
        int noe, nr;
        start_rec();
        Mem_OE = 1'b1; Mem_WE = 1'b1; MAR = 16'h0040; MDR = 16'hCAFE;
        run(8);
        noe = 0; nr = 0;
        for (int c = 1; c <= 8; c++) begin
            if (!oe_h[0][c]) noe++;
            if (r_h[0][c]) nr++;
        end
        n_vec++;
        if (mem0[8'h40] !== 16'hCAFE) begin n_err++; $display("FAIL both_write got %h want cafe", mem0[8'h40]); end
        n_vec++;
        if (noe !== 0 || nr !== 1) begin
            n_err++; $display("FAIL both_oe_r got oe_low=%0d pulses=%0d want 0 1", noe, nr);
        end
        Mem_OE = 1'b0; Mem_WE = 1'b0;
        run(2);
        start_rec();
        Mem_WE = 1'b1; MAR = 16'h0050; MDR = 16'h1111;
        run(3);
        n_vec++;
        if (we_h[0][3] !== 1'b0) begin n_err++; $display("FAIL rst_in_pulse we_n got %b want 0", we_h[0][3]); end
        Reset = 1'b1; Mem_WE = 1'b0;
        run(1);
        n_vec++;
        if ({we_n0, dq_oe0, mem_r0} !== 3'b100) begin
            n_err++; $display("FAIL rst_abort we/oe/r got %b want 100", {we_n0, dq_oe0, mem_r0});
        end
        n_vec++;
        if (hex0 !== 16'h0000) begin n_err++; $display("FAIL rst_hex got %h want 0000", hex0); end
        Reset = 1'b0;
        run(3);
        n_vec++;
        if ({r_h[0][5], r_h[0][6], r_h[0][7]} !== 3'b000) begin
            n_err++; $display("FAIL rst_no_mem_r got %b want 000", {r_h[0][5], r_h[0][6], r_h[0][7]});
        end
        start_rec();
        Mem_OE = 1'b1; MAR = 16'h0010;
        run(6);
        n_vec++;
        if (r_h[0][4] !== 1'b1 || data0 !== 16'h1234) begin
            n_err++; $display("FAIL rst_idle_read got mem_r=%b data=%h want 1 1234", r_h[0][4], data0);
        end
        Mem_OE = 1'b0;
        run(2);
    endtask

    task automatic test_wait_zero();
        int nwe, nr;
        start_rec();
        oe1 = 1'b1; MAR = 16'h0010;
        run(5);
        nr = 0;
        for (int c = 1; c <= 5; c++) if (r_h[1][c]) nr++;
        n_vec++;
        if (r_h[1][2] !== 1'b1 || nr !== 1) begin
            n_err++; $display("FAIL w0_rd_mem_r got c2=%b pulses=%0d want 1 1", r_h[1][2], nr);
        end
        n_vec++;
        if (data1 !== 16'h0777) begin n_err++; $display("FAIL w0_rd_data got %h want 0777", data1); end
        oe1 = 1'b0;
        run(2);
        start_rec();
        we1 = 1'b1; MAR = 16'h0060; MDR = 16'h3C3C;
        run(6);
        nwe = 0;
        for (int c = 1; c <= 6; c++) if (!we_h[1][c]) nwe++;
        n_vec++;
        if (nwe !== 1 || we_h[1][2] !== 1'b0) begin
            n_err++; $display("FAIL w0_we_pulse got n=%0d c2=%b want 1 0", nwe, we_h[1][2]);
        end
        n_vec++;
        if (r_h[1][3] !== 1'b1) begin n_err++; $display("FAIL w0_wr_mem_r got %b want 1", r_h[1][3]); end
        n_vec++;
        if (mem1[8'h60] !== 16'h3C3C) begin n_err++; $display("FAIL w0_stored got %h want 3c3c", mem1[8'h60]); end
        we1 = 1'b0;
        run(2);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 16'h0000;
        end
        mem0[8'h10] = 16'h1234;
        mem0[8'h30] = 16'h5555;
        mem1[8'h10] = 16'h0777;
        Reset = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0; oe1 = 1'b0; we1 = 1'b0;
        MAR = 16'h0000; MDR = 16'h0000; Switches = 16'h0000;
        run(2);
        test_reset();
        Reset = 1'b0;
        run(1);
        test_read();
        test_write();
        test_io();
        test_level_hold();
        test_both_and_reset();
        test_wait_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory-side stage directly downstream of the LC-3 control unit's Mem_OE/Mem_WE outputs.
- Converts level-held read/write requests into correctly timed asynchronous SRAM cycles.
- Decodes the memory-mapped I/O address: switches on read, hex display register on write.
- Returns a one-cycle completion strobe, so the control unit waits on Mem_R instead of fixed wait states.

Parameters:
WAIT_CYCLES, 3, SRAM access cycles: read data sample delay and WE_N low width. Legal values are 1..15; 0 is treated as 1.
IO_ADDR, 16'hFFFF, memory-mapped I/O address; never forwarded to SRAM.

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Mem_OE  in  1  read request, level, from control unit
Mem_WE  in  1  write request, level, from control unit
MAR  in  16  access address
MDR  in  16  write data
Switches  in  16  board switch inputs (I/O read source)
SRAM_DQ_in  in  16  data read from SRAM bus
Mem_R  out  1  access-complete strobe, one cycle
Data_out  out  16  registered read data, to MDR input mux
HEX_Reg  out  16  I/O write register, drives hex displays
SRAM_ADDR  out  20  SRAM address, {4'b0, latched MAR}
SRAM_DQ_out  out  16  write data to SRAM bus
SRAM_DQ_oe  out  1  tristate enable for SRAM_DQ_out
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM strobes, active low

Behaviour:
Reset
- Mem_R=0, Data_out=0, HEX_Reg=0, SRAM_ADDR=0, SRAM_DQ_oe=0.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N all =1.
- FSM goes to IDLE.
- Reset asserted mid-access aborts the access: all strobes are inactive on the next edge, no Mem_R, HEX_Reg cleared.

All outputs are registered. FSM states: IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_DONE, IO_DONE, HOLD.

IDLE
- Samples Mem_OE/Mem_WE each edge. If both are high, the write wins.
- On a request, latch MAR into the address register and MDR into the write-data register.
- Later changes to MAR or MDR do not affect the access in progress.

I/O access (latched address == IO_ADDR)
- Go to IO_DONE; no SRAM strobe is asserted.
- Read: Data_out <= Switches.
- Write: HEX_Reg <= latched MDR.
- Mem_R=1 for the single cycle in IO_DONE, then go to HOLD.

SRAM read
- Go to RD_WAIT and load the 4-bit counter with WAIT_CYCLES-1.
- In RD_WAIT: CE_N=OE_N=UB_N=LB_N=0, WE_N=1, DQ_oe=0. Counter decrements each cycle.
- When the counter reaches 0: capture Data_out <= SRAM_DQ_in and go to RD_DONE.
- RD_DONE: Mem_R=1, OE_N=1, then go to HOLD.
- Request sampled at edge 0 gives Mem_R high during cycle WAIT_CYCLES+1.

SRAM write
- WR_SETUP (1 cycle): CE_N=UB_N=LB_N=0, WE_N=1, OE_N=1, DQ_oe=1, address and data stable.
- WR_PULSE (WAIT_CYCLES cycles): WE_N=0.
- WR_DONE (1 cycle): WE_N=1 with data still driven (hold time), Mem_R=1, then go to HOLD.
- OE_N is never low while DQ_oe=1.

HOLD
- All strobes inactive, DQ_oe=0.
- Stay until Mem_OE=0 and Mem_WE=0, then go to IDLE.
- A level-held request therefore produces exactly one access and one Mem_R pulse.

Other rules
- Data_out and HEX_Reg hold their values between accesses.
- Mem_R is never high for two consecutive cycles.

Test Plan:
1. Reset, then Mem_OE=1, MAR=16'h0010, SRAM model returns 16'h1234 -> Mem_R high exactly in cycle 4 (WAIT_CYCLES=3); Data_out=16'h1234; SRAM_ADDR=20'h00010; WE_N stays 1.
2. Mem_WE=1, MAR=16'h0020, MDR=16'hBEEF -> WE_N low for exactly 3 cycles, framed by one setup and one hold cycle; DQ_oe=1 across all 5 cycles; model stores 16'hBEEF at 0x20; one Mem_R pulse.
3. Mem_OE=1, MAR=16'hFFFF, Switches=16'h00A5 -> Data_out=16'h00A5, Mem_R in cycle 1, CE_N never low. Then Mem_WE=1, MDR=16'h0042 -> HEX_Reg=16'h0042.
4. Mem_OE held high for 20 cycles, MAR changed to 16'h0030 at cycle 2 -> exactly one Mem_R; access uses address 0x0010. Dropping and reasserting Mem_OE starts a second access.
5. Mem_OE=Mem_WE=1 simultaneously -> write cycle performed, OE_N stays 1. Reset asserted during WR_PULSE -> WE_N=1 and DQ_oe=0 next cycle, no Mem_R, FSM in IDLE.
6. WAIT_CYCLES=0 -> behaves identically to 1: Mem_R in cycle 2 for a read, WE_N low exactly 1 cycle for a write.
